// File: rtl/carry_in_unit_pkg.sv
// carry_in_unit_pkg: carry-in select codes, lane-count constants and lane-count check
package carry_in_unit_pkg;
  localparam logic [2:0] CARRYINSEL_CARRYIN = 3'b000;
  localparam logic [2:0] CARRYINSEL_NPCIN   = 3'b001;
  localparam logic [2:0] CARRYINSEL_CASCIN  = 3'b010;
  localparam logic [2:0] CARRYINSEL_PCIN    = 3'b011;
  localparam logic [2:0] CARRYINSEL_CASCOUT = 3'b100;
  localparam logic [2:0] CARRYINSEL_NP      = 3'b101;
  localparam logic [2:0] CARRYINSEL_RND     = 3'b110;
  localparam logic [2:0] CARRYINSEL_P       = 3'b111;
  localparam int ONE48  = 1;
  localparam int TWO24  = 2;
  localparam int FOUR12 = 4;
  function automatic logic lanes_ok(input int n);
    return n == ONE48 || n == TWO24 || n == FOUR12;
  endfunction
endpackage

// File: rtl/carry_in_unit_if.sv
// carry_in_unit_if: carry-in sources, selects, clock enables and per-lane carry outputs
interface carry_in_unit_if #(parameter int LANES = 1);
  logic             CECARRYIN;
  logic             CECTRL;
  logic             CEM;
  logic [2:0]       carryinsel;
  logic             carryin;
  logic             carrycascin;
  logic             carrycascout;
  logic             MSB_Pcin;
  logic             MSB_P;
  logic             A24;
  logic             B17;
  logic [LANES-1:0] CIN;
  logic             sel_err;
  modport master (
    output CECARRYIN, CECTRL, CEM, carryinsel, carryin, carrycascin, carrycascout,
           MSB_Pcin, MSB_P, A24, B17,
    input  CIN, sel_err
  );
  modport slave (
    input  CECARRYIN, CECTRL, CEM, carryinsel, carryin, carrycascin, carrycascout,
           MSB_Pcin, MSB_P, A24, B17,
    output CIN, sel_err
  );
endinterface

// File: rtl/carry_in_unit_opt_reg.sv
// carry_in_unit_opt_reg: W-bit register with CE and async active-low clear, or a wire when EN_REG = 0
module carry_in_unit_opt_reg #(
  parameter int W      = 1,
  parameter bit EN_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (EN_REG) begin : g_reg
    logic [W-1:0] q_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q_q <= '0;
      else if (ce_i) q_q <= d_i;
    assign q_o = q_q;
  end else begin : g_byp
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, ce_i};
    assign q_o = d_i;
  end
endmodule

// File: rtl/carry_in_unit.sv
// carry_in_unit: DSP48E1 ALU carry-in select with optional sel/carryin/rounding registers and SIMD lanes
module carry_in_unit
  import carry_in_unit_pkg::*;
#(
  parameter bit CARRYINREG    = 1'b1,
  parameter bit CARRYINSELREG = 1'b1,
  parameter bit MREG          = 1'b1,
  parameter int LANES         = ONE48
) (
  input logic            clk,
  input logic            RSTALLCARRYIN_n,
  carry_in_unit_if.slave bus
);
  logic [2:0] sel;
  logic       cin_eff;
  logic       rnd_d;
  logic       rnd_eff;
  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("carry_in_unit: LANES must be 1, 2 or 4");
  end
  assign rnd_d = ~(bus.A24 ^ bus.B17);
  carry_in_unit_opt_reg #(.W(3), .EN_REG(CARRYINSELREG)) u_sel (
    .clk(clk), .rst_n(RSTALLCARRYIN_n), .ce_i(bus.CECTRL), .d_i(bus.carryinsel), .q_o(sel)
  );
  carry_in_unit_opt_reg #(.W(1), .EN_REG(CARRYINREG)) u_cin (
    .clk(clk), .rst_n(RSTALLCARRYIN_n), .ce_i(bus.CECARRYIN), .d_i(bus.carryin), .q_o(cin_eff)
  );
  carry_in_unit_opt_reg #(.W(1), .EN_REG(MREG)) u_rnd (
    .clk(clk), .rst_n(RSTALLCARRYIN_n), .ce_i(bus.CEM), .d_i(rnd_d), .q_o(rnd_eff)
  );
  if (LANES == ONE48) begin : g_one
    logic [7:0] srcs;
    // bit position equals the select code
    assign srcs = {bus.MSB_P, rnd_eff, ~bus.MSB_P, bus.carrycascout,
                   bus.MSB_Pcin, bus.carrycascin, ~bus.MSB_Pcin, cin_eff};
    assign bus.CIN     = srcs[sel];
    assign bus.sel_err = 1'b0;
  end else begin : g_simd
    logic unused_rnd;
    assign unused_rnd  = rnd_eff;
    assign bus.sel_err = sel != CARRYINSEL_CARRYIN;
    assign bus.CIN     = bus.sel_err ? '0 : {{(LANES-1){1'b0}}, cin_eff};
  end
endmodule

// File: tb/tb_carry_in_unit.sv
// tb_carry_in_unit: directed vectors for registered, bypassed and SIMD carry_in_unit configurations
module tb_carry_in_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  carry_in_unit_if #(.LANES(1)) ifr ();
  carry_in_unit_if #(.LANES(1)) ifb ();
  carry_in_unit_if #(.LANES(4)) ifs ();
  carry_in_unit #(.CARRYINREG(1), .CARRYINSELREG(1), .MREG(1), .LANES(1)) u_reg (
    .clk(clk), .RSTALLCARRYIN_n(rst_n), .bus(ifr)
  );
  carry_in_unit #(.CARRYINREG(0), .CARRYINSELREG(0), .MREG(0), .LANES(1)) u_byp (
    .clk(clk), .RSTALLCARRYIN_n(rst_n), .bus(ifb)
  );
  carry_in_unit #(.CARRYINREG(0), .CARRYINSELREG(0), .MREG(0), .LANES(4)) u_simd (
    .clk(clk), .RSTALLCARRYIN_n(rst_n), .bus(ifs)
  );
  typedef struct {
    logic [2:0] sel;
    logic [6:0] src;
    logic       exp;
  } vec_t;
  vec_t vt[16];
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_comb(input logic [2:0] sel, input logic [6:0] s);
    {ifb.carryin, ifb.carrycascin, ifb.carrycascout, ifb.MSB_Pcin, ifb.MSB_P, ifb.A24, ifb.B17} = s;
    {ifs.carryin, ifs.carrycascin, ifs.carrycascout, ifs.MSB_Pcin, ifs.MSB_P, ifs.A24, ifs.B17} = s;
    ifb.carryinsel = sel;
    ifs.carryinsel = sel;
  endtask
  initial begin
    // src = {carryin, carrycascin, carrycascout, MSB_Pcin, MSB_P, A24, B17}
    vt[0]  = '{3'b000, 7'b1000000, 1'b1};
    vt[1]  = '{3'b001, 7'b0001000, 1'b0};
    vt[2]  = '{3'b010, 7'b0100000, 1'b1};
    vt[3]  = '{3'b011, 7'b0001000, 1'b1};
    vt[4]  = '{3'b100, 7'b0010000, 1'b1};
    vt[5]  = '{3'b101, 7'b0000100, 1'b0};
    vt[6]  = '{3'b110, 7'b0000011, 1'b1};
    vt[7]  = '{3'b111, 7'b0000100, 1'b1};
    vt[8]  = '{3'b001, 7'b0000000, 1'b1};
    vt[9]  = '{3'b101, 7'b0000000, 1'b1};
    vt[10] = '{3'b110, 7'b0000000, 1'b1};
    vt[11] = '{3'b110, 7'b0000010, 1'b0};
    vt[12] = '{3'b000, 7'b0111111, 1'b0};
    vt[13] = '{3'b011, 7'b1110111, 1'b0};
    vt[14] = '{3'b100, 7'b1101111, 1'b0};
    vt[15] = '{3'b010, 7'b1011111, 1'b0};
    {ifr.CECARRYIN, ifr.CECTRL, ifr.CEM} = 3'b111;
    ifr.carryinsel = 3'b000;
    {ifr.carryin, ifr.carrycascin, ifr.carrycascout, ifr.MSB_Pcin, ifr.MSB_P, ifr.A24, ifr.B17} = 7'b1000000;
    {ifb.CECARRYIN, ifb.CECTRL, ifb.CEM} = 3'b000;
    {ifs.CECARRYIN, ifs.CECTRL, ifs.CEM} = 3'b000;
    drive_comb(3'b000, 7'b0000000);
    repeat (2) tick();
    check("reset_cin", 4'(ifr.CIN), 4'h0);
    check("reset_err", 4'(ifr.sel_err), 4'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_reset_cin", 4'(ifr.CIN), 4'h1);
    ifr.carryin = 1'b0;
    ifr.A24 = 1'b1;
    tick();
    check("cin_reg_load0", 4'(ifr.CIN), 4'h0);
    ifr.CEM = 1'b0;
    ifr.carryinsel = 3'b011;
    ifr.MSB_Pcin = 1'b1;
    #1;
    check("sel_same_cycle", 4'(ifr.CIN), 4'h0);
    tick();
    check("sel_next_cycle", 4'(ifr.CIN), 4'h1);
    ifr.CECTRL = 1'b0;
    ifr.carryinsel = 3'b000;
    tick();
    check("sel_hold_ce0", 4'(ifr.CIN), 4'h1);
    ifr.MSB_Pcin = 1'b0;
    #1;
    check("pcin_comb", 4'(ifr.CIN), 4'h0);
    ifr.MSB_Pcin = 1'b1;
    ifr.CECTRL = 1'b1;
    ifr.carryinsel = 3'b110;
    ifr.B17 = 1'b1;
    tick();
    check("rnd_before_cem", 4'(ifr.CIN), 4'h0);
    ifr.CEM = 1'b1;
    tick();
    check("rnd_cem_pulse", 4'(ifr.CIN), 4'h1);
    ifr.CEM = 1'b0;
    ifr.A24 = 1'b0;
    tick();
    check("rnd_hold_cem0", 4'(ifr.CIN), 4'h1);
    ifr.CEM = 1'b1;
    tick();
    check("rnd_reload0", 4'(ifr.CIN), 4'h0);
    ifr.CEM = 1'b0;
    ifr.carryinsel = 3'b000;
    ifr.carryin = 1'b1;
    tick();
    check("midrun_loaded", 4'(ifr.CIN), 4'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_async_clear", 4'(ifr.CIN), 4'h0);
    ifr.CECARRYIN = 1'b0;
    tick();
    check("midrun_in_reset", 4'(ifr.CIN), 4'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("midrun_release_ce0", 4'(ifr.CIN), 4'h0);
    ifr.CECARRYIN = 1'b1;
    tick();
    check("midrun_first_ce", 4'(ifr.CIN), 4'h1);
    for (int i = 0; i < 16; i++) begin
      drive_comb(vt[i].sel, vt[i].src);
      #1;
      check($sformatf("byp_vec%0d", i), 4'(ifb.CIN), 4'(vt[i].exp));
      check($sformatf("simd_cin_vec%0d", i), ifs.CIN,
            vt[i].sel == 3'b000 ? {3'b000, vt[i].src[6]} : 4'b0000);
      check($sformatf("simd_err_vec%0d", i), 4'(ifs.sel_err), 4'(vt[i].sel != 3'b000));
      check($sformatf("byp_err_vec%0d", i), 4'(ifb.sel_err), 4'h0);
    end
    drive_comb(3'b000, 7'b1000000);
    #1;
    check("simd_sel000_cin", ifs.CIN, 4'b0001);
    check("simd_sel000_err", 4'(ifs.sel_err), 4'h0);
    drive_comb(3'b010, 7'b1100000);
    #1;
    check("simd_sel010_cin", ifs.CIN, 4'b0000);
    check("simd_sel010_err", 4'(ifs.sel_err), 4'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
